// File: rtl/reg_file_pkg.sv
// Shared types and limits for the multi-port register file and its clear sweep.
package reg_file_pkg;

  typedef enum logic {IDLE, SWEEP} rf_state_t;

  localparam int unsigned RF_MAX_RP = 4;

endpackage

// File: rtl/reg_file_sweep.sv
// Control for the self-timed clear: walks every address once after reset or init.
module reg_file_sweep
  import reg_file_pkg::*;
#(
  parameter int unsigned D = 3
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         init_i,
  output logic         busy_o,
  output logic         clr_en_o,
  output logic [D-1:0] clr_addr_o
);

  rf_state_t    state_q, state_d;
  logic [D-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (init_i) begin
      // A restart always begins at 0 so no address escapes the clear.
      state_d = SWEEP;
      cnt_d   = '0;
    end else if (state_q == SWEEP) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {D{1'b1}}) begin
        state_d = IDLE;
      end
    end
  end

  assign busy_o     = (state_q == SWEEP);
  assign clr_en_o   = (state_q == SWEEP);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: RP combinational reads, two prioritised writes,
// optional bypass and zero register, cleared by a sweep instead of a reset.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned D       = 3,
  parameter int unsigned RP      = 2,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned ZERO_R0 = 0
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         init_i,
  output logic         busy_o,
  input  logic         we0_i,
  input  logic         we1_i,
  input  logic [D-1:0] waddr0_i,
  input  logic [D-1:0] waddr1_i,
  input  logic [W-1:0] wdata0_i,
  input  logic [W-1:0] wdata1_i,
  input  logic [D-1:0] raddr_i [RP],
  output logic [W-1:0] rdata_o [RP],
  output logic         wr_drop_o
);

  localparam int unsigned N = 1 << D;

  if (RP < 1 || RP > RF_MAX_RP) begin : g_bad_rp
    $error("reg_file_mp: RP out of range");
  end

  logic         busy;
  logic         clr_en;
  logic [D-1:0] clr_addr;
  logic         wen0, wen1;
  logic         wr_drop_q, wr_drop_d;
  logic [W-1:0] mem_q [N];

  reg_file_sweep #(
    .D (D)
  ) u_sweep (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .init_i     (init_i),
    .busy_o     (busy),
    .clr_en_o   (clr_en),
    .clr_addr_o (clr_addr)
  );

  assign wen0 = we0_i && !busy && !((ZERO_R0 != 0) && (waddr0_i == '0));
  assign wen1 = we1_i && !busy && !((ZERO_R0 != 0) && (waddr1_i == '0));

  // No reset on the array; the later assignment gives port 1 priority.
  always_ff @(posedge clk_i) begin
    if (clr_en) begin
      mem_q[clr_addr] <= '0;
    end else begin
      if (wen0) mem_q[waddr0_i] <= wdata0_i;
      if (wen1) mem_q[waddr1_i] <= wdata1_i;
    end
  end

  assign wr_drop_d = busy && (we0_i || we1_i);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= wr_drop_d;
    end
  end

  always_comb begin
    for (int p = 0; p < RP; p++) begin
      rdata_o[p] = mem_q[raddr_i[p]];
      if (BYPASS != 0) begin
        if (we0_i && (waddr0_i == raddr_i[p])) rdata_o[p] = wdata0_i;
        if (we1_i && (waddr1_i == raddr_i[p])) rdata_o[p] = wdata1_i;
      end
      if ((ZERO_R0 != 0) && (raddr_i[p] == '0)) rdata_o[p] = '0;
      if (busy) rdata_o[p] = '0;
    end
  end

  assign busy_o    = busy;
  assign wr_drop_o = wr_drop_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench: three parameterisations share one stimulus stream.
module tb_reg_file_mp;

  logic       clk_i = 1'b0;
  logic       reset_i, init_i;
  logic       we0_i, we1_i;
  logic [2:0] waddr0_i, waddr1_i;
  logic [7:0] wdata0_i, wdata1_i;
  logic [2:0] raddr_i [2];

  logic       busy_b, busy_n, busy_z;
  logic       drop_b, drop_n, drop_z;
  logic [7:0] rd_b [2];
  logic [7:0] rd_n [2];
  logic [7:0] rd_z [2];

  int checks = 0;
  int fails  = 0;

  always #5 clk_i = ~clk_i;

  reg_file_mp #(.W(8), .D(3), .RP(2), .BYPASS(1), .ZERO_R0(0)) u_byp (
    .clk_i(clk_i), .reset_i(reset_i), .init_i(init_i), .busy_o(busy_b),
    .we0_i(we0_i), .we1_i(we1_i), .waddr0_i(waddr0_i), .waddr1_i(waddr1_i),
    .wdata0_i(wdata0_i), .wdata1_i(wdata1_i), .raddr_i(raddr_i), .rdata_o(rd_b),
    .wr_drop_o(drop_b)
  );

  reg_file_mp #(.W(8), .D(3), .RP(2), .BYPASS(0), .ZERO_R0(0)) u_nob (
    .clk_i(clk_i), .reset_i(reset_i), .init_i(init_i), .busy_o(busy_n),
    .we0_i(we0_i), .we1_i(we1_i), .waddr0_i(waddr0_i), .waddr1_i(waddr1_i),
    .wdata0_i(wdata0_i), .wdata1_i(wdata1_i), .raddr_i(raddr_i), .rdata_o(rd_n),
    .wr_drop_o(drop_n)
  );

  reg_file_mp #(.W(8), .D(3), .RP(2), .BYPASS(1), .ZERO_R0(1)) u_zero (
    .clk_i(clk_i), .reset_i(reset_i), .init_i(init_i), .busy_o(busy_z),
    .we0_i(we0_i), .we1_i(we1_i), .waddr0_i(waddr0_i), .waddr1_i(waddr1_i),
    .wdata0_i(wdata0_i), .wdata1_i(wdata1_i), .raddr_i(raddr_i), .rdata_o(rd_z),
    .wr_drop_o(drop_z)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the posedge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_busy(input string tag, input logic exp);
    chk({tag, "_b"}, {7'd0, busy_b}, {7'd0, exp});
    chk({tag, "_n"}, {7'd0, busy_n}, {7'd0, exp});
    chk({tag, "_z"}, {7'd0, busy_z}, {7'd0, exp});
  endtask

  task automatic chk_all_zero(input string tag);
    for (int a = 0; a < 8; a++) begin
      raddr_i[0] = 3'(a);
      raddr_i[1] = 3'(7 - a);
      #1;
      chk({tag, "_b0"}, rd_b[0], 8'h00);
      chk({tag, "_b1"}, rd_b[1], 8'h00);
      chk({tag, "_n0"}, rd_n[0], 8'h00);
      chk({tag, "_z0"}, rd_z[0], 8'h00);
    end
  endtask

  initial begin
    reset_i  = 1'b1;
    init_i   = 1'b0;
    we0_i    = 1'b0;
    we1_i    = 1'b0;
    waddr0_i = '0;
    waddr1_i = '0;
    wdata0_i = '0;
    wdata1_i = '0;
    raddr_i[0] = '0;
    raddr_i[1] = '0;

    // Reset state
    tick();
    chk_busy("rst_busy", 1'b1);
    chk("rst_drop", {7'd0, drop_b}, 8'h00);
    chk("rst_rd0", rd_b[0], 8'h00);
    tick();
    reset_i = 1'b0;
    #1;

    // Sweep lasts exactly 8 cycles after release
    for (int i = 0; i < 8; i++) begin
      chk_busy("swp_busy", 1'b1);
      chk("swp_drop", {7'd0, drop_b}, 8'h00);
      tick();
    end
    chk_busy("swp_done", 1'b0);
    chk("swp_drop_end", {7'd0, drop_b}, 8'h00);
    chk_all_zero("post_rst");

    // Port 0 write of 0xA5 to r3: bypass vs storage
    we0_i = 1'b1; waddr0_i = 3'd3; wdata0_i = 8'hA5; raddr_i[0] = 3'd3;
    #1;
    chk("byp_a5", rd_b[0], 8'hA5);
    chk("nob_old", rd_n[0], 8'h00);
    tick();
    we0_i = 1'b0;
    #1;
    chk("stored_a5_b", rd_b[0], 8'hA5);
    chk("stored_a5_n", rd_n[0], 8'hA5);

    // Both ports to r5: port 1 wins
    we0_i = 1'b1; waddr0_i = 3'd5; wdata0_i = 8'h11;
    we1_i = 1'b1; waddr1_i = 3'd5; wdata1_i = 8'h22;
    raddr_i[0] = 3'd5; raddr_i[1] = 3'd5;
    #1;
    chk("pri_byp0", rd_b[0], 8'h22);
    chk("pri_byp1", rd_b[1], 8'h22);
    chk("pri_nob0", rd_n[0], 8'h00);
    tick();
    we0_i = 1'b0; we1_i = 1'b0;
    #1;
    chk("pri_st_n0", rd_n[0], 8'h22);
    chk("pri_st_n1", rd_n[1], 8'h22);
    chk("pri_st_b1", rd_b[1], 8'h22);

    // Zero register: writes to r0 vanish, r1 behaves normally
    we0_i = 1'b1; waddr0_i = 3'd0; wdata0_i = 8'hFF; raddr_i[0] = 3'd0;
    we1_i = 1'b1; waddr1_i = 3'd1; wdata1_i = 8'h5C; raddr_i[1] = 3'd1;
    #1;
    chk("z_r0_byp", rd_z[0], 8'h00);
    chk("z_r1_byp", rd_z[1], 8'h5C);
    chk("b_r0_byp", rd_b[0], 8'hFF);
    tick();
    we0_i = 1'b0; we1_i = 1'b0;
    #1;
    chk("z_r0_st", rd_z[0], 8'h00);
    chk("z_r1_st", rd_z[1], 8'h5C);
    chk("b_r0_st", rd_b[0], 8'hFF);

    // init sweep with a dropped write in its third cycle
    we0_i = 1'b1; waddr0_i = 3'd2; wdata0_i = 8'h7E; raddr_i[0] = 3'd2;
    tick();
    we0_i = 1'b0;
    #1;
    chk("r2_7e", rd_n[0], 8'h7E);
    init_i = 1'b1;
    tick();
    init_i = 1'b0;
    #1;
    chk_busy("init_c1", 1'b1);
    chk("init_rd", rd_b[0], 8'h00);
    tick();
    tick();
    we0_i = 1'b1; waddr0_i = 3'd2; wdata0_i = 8'h33;
    #1;
    chk("drop_pre", {7'd0, drop_b}, 8'h00);
    tick();
    we0_i = 1'b0;
    #1;
    chk("drop_pulse_b", {7'd0, drop_b}, 8'h01);
    chk("drop_pulse_z", {7'd0, drop_z}, 8'h01);
    tick();
    chk("drop_once", {7'd0, drop_b}, 8'h00);
    chk_busy("init_c5", 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_busy("init_tail", 1'b1);
    end
    tick();
    chk_busy("init_done", 1'b0);
    raddr_i[0] = 3'd2; raddr_i[1] = 3'd3;
    #1;
    chk("r2_cleared", rd_n[0], 8'h00);
    chk("r3_cleared", rd_n[1], 8'h00);

    // Reset in the fourth cycle of a sweep restarts a full sweep
    we1_i = 1'b1; waddr1_i = 3'd4; wdata1_i = 8'h99;
    tick();
    we1_i = 1'b0;
    init_i = 1'b1;
    tick();
    init_i = 1'b0;
    tick();
    tick();
    tick();
    reset_i = 1'b1;
    #1;
    chk_busy("mid_rst", 1'b1);
    chk("mid_rst_drop", {7'd0, drop_b}, 8'h00);
    tick();
    reset_i = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk_busy("rst2_busy", 1'b1);
      tick();
    end
    chk_busy("rst2_done", 1'b0);
    chk_all_zero("post_rst2");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port successor to the 8x8 register file: `2**D` registers of `W` bits, `RP` combinational read ports, and two write ports with fixed priority. It adds optional same-cycle write-to-read bypass, an optional hard-wired zero register, and a self-timed clear sweep. The sweep replaces the one-cycle bulk init, so the storage array needs no reset and stays RAM-inferable. It sits in the datapath between decode (addresses) and the ALU/writeback stage.

## Interface
- `W`, 8, data width
- `D`, 3, address width; `2**D` registers
- `RP`, 2, number of read ports (1..4)
- `BYPASS`, 1, 1 = same-cycle write data forwarded to matching reads
- `ZERO_R0`, 0, 1 = register 0 reads as 0 and ignores writes
- `clk`  in  1  clock; all state changes on posedge
- `reset`  in  1  asynchronous, active-high; forces control into SWEEP
- `init`  in  1  synchronous clear request; (re)starts the sweep
- `busy`  out  1  high while the sweep runs
- `we0`, `we1`  in  1 each  write enables; port 1 has priority
- `waddr0`, `waddr1`  in  D each  write addresses
- `wdata0`, `wdata1`  in  W each  write data
- `raddr[RP]`  in  D each  read addresses
- `rdata[RP]`  out  W each  read data, combinational
- `wr_drop`  out  1  registered; pulses one cycle for each cycle in which a write was discarded because `busy`

## Operation
- Storage array has no reset. Only the control state (FSM, sweep counter, `wr_drop`) is reset.
- FSM states:
  - SWEEP: each cycle writes 0 to `reg[cnt]`, then `cnt <= cnt+1`. After the cycle with `cnt == 2**D-1`, goes to IDLE.
  - IDLE: normal operation. `init=1` in IDLE goes to SWEEP with `cnt=0`.
- `init=1` during SWEEP restarts the sweep at `cnt=0` (no clear is skipped).
- `reset` asserted mid-sweep or mid-write: control goes immediately to SWEEP with `cnt=0`. A partial write in that cycle is don't-care, because the sweep overwrites it.
- Writes in IDLE:
  - `we0`/`we1` write their data at the posedge.
  - Both enabled to the same address: `wdata1` is stored.
  - `ZERO_R0=1`: writes to address 0 are ignored.
- Writes while `busy`: discarded. `wr_drop` is 1 in the following cycle if `we0|we1` was high.
- Reads, resolved per port:
  - `busy=1` → 0.
  - `ZERO_R0=1` and `raddr==0` → 0.
  - `BYPASS=1` and `we1 && waddr1==raddr` → `wdata1`.
  - `BYPASS=1` and `we0 && waddr0==raddr` → `wdata0`.
  - Otherwise the stored value.
- Reset values:
  - `busy=1`, because reset enters SWEEP.
  - `wr_drop=0`.
  - `rdata`=0, because `busy` forces it.

## Timing
- Read latency is 0 cycles (combinational from `raddr`).
- Write-to-read latency: 1 cycle through storage, or 0 cycles with `BYPASS=1`.
- Sweep is exactly `2**D` cycles from reset release, or from the posedge that samples `init`.
  - `busy` is high for those `2**D` cycles.
  - The first write is accepted on the first posedge with `busy=0`.
- `wr_drop` lags the dropped write by one cycle. It is never high for 2 cycles for a single dropped write.

## Structure
- Package `reg_file_pkg`:
  - `typedef enum logic {IDLE, SWEEP} rf_state_t`.
  - Read-port limit constant `RF_MAX_RP = 4`.
- Sub-module `reg_file_sweep`:
  - Holds the FSM and the D-bit counter.
  - Outputs `busy`, `clr_en`, `clr_addr`.
- Top level holds the array, write muxing (sweep > port 1 > port 0), read/bypass muxing, and the `wr_drop` flop.

## Test plan
All scenarios use W=8, D=3, RP=2.
- Reset release: `busy`=1 for 8 cycles, then 0. Every `raddr` 0..7 reads 0x00 afterward. `wr_drop`=0 throughout.
- Write 0xA5 to r3 via port 0, then read port 0 at r3 the next cycle → 0xA5. With `BYPASS=1`, the same cycle also shows 0xA5. With `BYPASS=0`, the same cycle shows the old value 0x00.
- Same cycle: `we0` r5=0x11 and `we1` r5=0x22 → r5 reads 0x22. Both read ports show 0x22 in the bypass cycle.
- `init` pulse with r2=0x7E, then `we0` r2=0x33 during cycle 3 of the sweep → `wr_drop`=1 for one cycle. After `busy` falls, r2=0x00.
- `ZERO_R0=1`: write 0xFF to r0 → r0 reads 0x00, including the bypass path. A write to r1 works normally.
- `reset` asserted at cycle 4 of a sweep, then released → `busy` is high for a full 8 cycles from release, and all registers read 0x00.
